// File: rtl/rgbw_pwm_bank.sv
// Multi-channel PWM bank: SPI-fed shadow duty registers, committed atomically at the
// period wrap, with optional per-channel phase staggering to spread LED current steps.
module rgbw_pwm_bank #(
    parameter int CH    = 4,
    parameter int W     = 8,
    parameter int PRESC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_rdy,
    input  logic          cs,
    output logic [CH-1:0] pwm_out,
    output logic          period_tick,
    output logic          commit_pending
);
    localparam int              PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC - 1);
    localparam logic [W-1:0]    CNT_LAST   = '1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [3:0]      ptr_q, ptr_d;
    logic            dirty_q, dirty_d;
    logic            pend_q, pend_d;
    logic            smode_q, smode_d;
    logic            amode_q, amode_d;
    logic [CH*W-1:0] shadow_q, shadow_d;
    logic [CH*W-1:0] active_q, active_d;
    logic [CH-1:0]   pwm_q, pwm_d;
    logic            ptick_q;
    logic            tick, wrap, commit, wr_en, pend_set;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        wrap    = tick && (cnt_q == CNT_LAST);
        commit  = wrap && pend_q;
        presc_d = tick ? '0 : presc_q + PW'(1);
        cnt_d   = tick ? cnt_q + W'(1) : cnt_q;
        amode_d = commit ? smode_q : amode_q;
        // A close on the commit edge re-arms pending; the re-commit is a harmless repeat.
        pend_d  = pend_set | (pend_q & ~commit);
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        dirty_d  = dirty_q;
        smode_d  = smode_q;
        wr_en    = 1'b0;
        pend_set = 1'b0;
        if (cs) begin
            // Frame end wins over any byte strobed on the same cycle.
            state_d  = S_IDLE;
            pend_set = dirty_q;
            dirty_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_HDR;
                S_HDR: begin
                    if (rx_rdy) begin
                        smode_d = rx_data[7];
                        ptr_d   = rx_data[3:0];
                        dirty_d = 1'b1;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (rx_rdy) begin
                        if (int'(ptr_q) < CH) begin
                            wr_en   = 1'b1;
                            dirty_d = 1'b1;
                        end
                        if (ptr_q != 4'hF) begin
                            ptr_d = ptr_q + 4'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            localparam logic [W-1:0] OFF = W'((gi * ((1 << W) / CH)) % (1 << W));
            logic [W-1:0] phase;
            assign shadow_d[gi*W +: W] = (wr_en && ptr_q == 4'(gi)) ? rx_data[7 -: W]
                                                                   : shadow_q[gi*W +: W];
            assign active_d[gi*W +: W] = commit ? shadow_q[gi*W +: W] : active_q[gi*W +: W];
            // Built from next-state values so the output edge lines up with cnt_q.
            assign phase     = amode_d ? cnt_d + OFF : cnt_d;
            assign pwm_d[gi] = (phase < active_d[gi*W +: W]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            dirty_q  <= 1'b0;
            pend_q   <= 1'b0;
            smode_q  <= 1'b0;
            amode_q  <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= '0;
            ptick_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            dirty_q  <= dirty_d;
            pend_q   <= pend_d;
            smode_q  <= smode_d;
            amode_q  <= amode_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
            ptick_q  <= wrap;
        end
    end

    assign pwm_out        = pwm_q;
    assign period_tick    = ptick_q;
    assign commit_pending = pend_q;
endmodule

// File: tb/tb_rgbw_pwm_bank.sv
// Bench for rgbw_pwm_bank: frames push expected committed configurations into a queue;
// a monitor pops them at each period wrap and checks the whole period's waveforms.
module tb_rgbw_pwm_bank;
    localparam int CH    = 4;
    localparam int W     = 8;
    localparam int PRESC = 2;
    localparam int NT    = 1 << W;
    localparam int PLEN  = NT * PRESC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_rdy = 1'b0;
    logic          cs = 1'b1;
    logic [CH-1:0] pwm_out;
    logic          period_tick;
    logic          commit_pending;

    rgbw_pwm_bank #(.CH(CH), .W(W), .PRESC(PRESC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_rdy         (rx_rdy),
        .cs             (cs),
        .pwm_out        (pwm_out),
        .period_tick    (period_tick),
        .commit_pending (commit_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: shadow contents as the frame rules define them.
    typedef struct {
        int         close_cyc;
        bit         mode;
        logic [127:0] duty;
    } exp_t;

    exp_t       exp_q[$];
    int         m_duty[16];
    bit         m_mode;
    logic [7:0] fbuf[16];

    function automatic bit exp_bit(input int k, input int t, input bit mode, input int duty);
        int phase;
        phase = mode ? (t + k * (NT / CH)) % NT : t;
        return phase < duty;
    endfunction

    // Monitor state
    bit           started = 1'b0;
    int           wrap_cyc = 0;
    bit           cur_mode = 1'b0;
    logic [127:0] cur_duty = '0;
    int           werr[CH];
    int           perr = 0;
    int           mon_d;
    bit           mon_ep;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            started  = 1'b0;
            cur_mode = 1'b0;
            cur_duty = '0;
        end else begin
            if (period_tick) begin
                if (started) begin
                    check("period_len", cyc - wrap_cyc, PLEN);
                    check("pending_track", perr, 0);
                    for (int k = 0; k < CH; k++) begin
                        check($sformatf("ch%0d_wave_errs", k), werr[k], 0);
                    end
                end
                check("pending_at_wrap", commit_pending, 0);
                while (exp_q.size() > 0 && exp_q[0].close_cyc < cyc) begin
                    mon_e    = exp_q.pop_front();
                    cur_mode = mon_e.mode;
                    cur_duty = mon_e.duty;
                end
                wrap_cyc = cyc;
                started  = 1'b1;
                perr     = 0;
                for (int k = 0; k < CH; k++) werr[k] = 0;
            end
            if (started) begin
                mon_ep = (exp_q.size() > 0 && exp_q[0].close_cyc <= cyc);
                if (commit_pending !== mon_ep) perr++;
                mon_d = cyc - wrap_cyc;
                if (mon_d % PRESC == 0 && mon_d / PRESC < NT) begin
                    for (int k = 0; k < CH; k++) begin
                        if (pwm_out[k] !== exp_bit(k, mon_d / PRESC, cur_mode,
                                                   int'(cur_duty[k*8 +: 8])))
                            werr[k]++;
                    end
                end
            end
        end
    end

    task automatic wait_ptick();
        for (int i = 0; i < PLEN * 2 + 10; i++) begin
            @(negedge clk);
            if (period_tick === 1'b1) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL ptick_timeout: got no period_tick, expected one within %0d clk", PLEN * 2 + 10);
    endtask

    task automatic send_frame(input int nb, input bit do_close, input bit rand_gaps);
        int ptr;
        int gap;
        exp_t e;
        ptr = 0;
        @(posedge clk); #1;
        cs = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < nb; i++) begin
            rx_rdy  = 1'b1;
            rx_data = fbuf[i];
            if (i == 0) begin
                m_mode = fbuf[i][7];
                ptr    = int'(fbuf[i][3:0]);
            end else begin
                if (ptr < CH) m_duty[ptr] = int'(fbuf[i]) >> (8 - W);
                if (ptr < 15) ptr++;
            end
            @(posedge clk); #1;
            rx_rdy = 1'b0;
            gap = rand_gaps ? $urandom_range(0, 2) : 0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
        if (do_close) begin
            cs = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                rx_rdy  = 1'b1;
                rx_data = 8'($urandom);
            end
            e.close_cyc = cyc + 1;
            e.mode      = m_mode;
            e.duty      = '0;
            for (int k = 0; k < 16; k++) e.duty[k*8 +: 8] = 8'(m_duty[k]);
            exp_q.push_back(e);
            @(posedge clk); #1;
            rx_rdy = 1'b0;
            check("pending_after_close", commit_pending, 1);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pwm_out", pwm_out, 0);
        check("rst_pending", commit_pending, 0);
        check("rst_ptick", period_tick, 0);
        exp_q.delete();
        for (int k = 0; k < 16; k++) m_duty[k] = 0;
        m_mode = 1'b0;
        cs     = 1'b1;
        rx_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic directed(input int nb);
        wait_ptick();
        repeat (3) @(posedge clk);
        send_frame(nb, 1'b1, 1'b0);
        wait_ptick();
        wait_ptick();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) m_duty[k] = 0;
        m_mode = 1'b0;
        for (int k = 0; k < CH; k++) werr[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("init_pwm_out", pwm_out, 0);
        check("init_pending", commit_pending, 0);
        check("init_ptick", period_tick, 0);
        rst_n = 1'b1;

        // Idle periods: outputs stay low, period_tick spacing checked by the monitor.
        repeat (3) wait_ptick();

        fbuf[0] = 8'h00; fbuf[1] = 8'h40; fbuf[2] = 8'h80; fbuf[3] = 8'hC0; fbuf[4] = 8'hFF;
        directed(5);

        fbuf[0] = 8'h80; fbuf[1] = 8'h80; fbuf[2] = 8'h80; fbuf[3] = 8'h80; fbuf[4] = 8'h80;
        directed(5);

        fbuf[0] = 8'h03; fbuf[1] = 8'h20; fbuf[2] = 8'h55;
        directed(3);

        // Two frames inside one pending window: only the final shadow state is committed.
        wait_ptick();
        repeat (3) @(posedge clk);
        fbuf[0] = 8'h00; fbuf[1] = 8'h30;
        send_frame(2, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        fbuf[0] = 8'h00; fbuf[1] = 8'h10;
        send_frame(2, 1'b1, 1'b0);
        wait_ptick();
        wait_ptick();

        // Reset while a closed frame is pending and a second frame is half written.
        wait_ptick();
        repeat (3) @(posedge clk);
        fbuf[0] = 8'h00; fbuf[1] = 8'h33; fbuf[2] = 8'h44;
        send_frame(3, 1'b1, 1'b0);
        fbuf[0] = 8'h00; fbuf[1] = 8'h77; fbuf[2] = 8'h66;
        send_frame(3, 1'b0, 1'b0);
        apply_reset();
        wait_ptick();
        repeat (3) @(posedge clk);
        fbuf[0] = 8'h81;
        send_frame(1, 1'b1, 1'b0);
        wait_ptick();
        wait_ptick();

        // Randomized frames, sometimes two per pending window, with random byte gaps.
        for (int it = 0; it < 12; it++) begin
            int nf;
            int nb;
            wait_ptick();
            repeat ($urandom_range(0, 15)) @(posedge clk);
            nf = $urandom_range(1, 2);
            for (int f = 0; f < nf; f++) begin
                nb = $urandom_range(1, 6);
                fbuf[0] = {1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom_range(0, 6))};
                for (int i = 1; i < nb; i++) fbuf[i] = 8'($urandom);
                send_frame(nb, 1'b1, 1'b1);
            end
        end
        wait_ptick();
        wait_ptick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        n_bad++;
        $display("FAIL watchdog: got no completion, expected finish before 600000 ns");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
